// File: rtl/instruction_fetch_bridge_if.sv
// Instruction memory bus between the fetch bridge (master) and the
// instruction memory (slave): a valid/ready request channel and a response
// channel with no backpressure.
interface instruction_fetch_bridge_if;
  logic        memRequestValid;
  logic        memRequestReady;
  logic [31:0] memRequestAddress;
  logic        memResponseValid;
  logic [31:0] memResponseData;
  logic        memResponseError;

  modport master (
    output memRequestValid,
    output memRequestAddress,
    input  memRequestReady,
    input  memResponseValid,
    input  memResponseData,
    input  memResponseError
  );

  modport slave (
    input  memRequestValid,
    input  memRequestAddress,
    output memRequestReady,
    output memResponseValid,
    output memResponseData,
    output memResponseError
  );
endinterface

// File: rtl/instruction_fetch_bridge.sv
// Instruction fetch bridge: turns the combinational PC from Fetch into
// single-outstanding bus requests and keeps the returned word in a one-entry
// hold buffer. The buffer answers Fetch combinationally whenever its address
// matches the PC. Stale responses (after a PC change or invalidate) are dropped.
module instruction_fetch_bridge #(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [31:0]                  instructionAddress,
  input  logic                         invalidate,
  instruction_fetch_bridge_if.master   mem,
  output logic                         instructionDataValid,
  output logic [31:0]                  instructionData,
  output logic                         fetchFault
);

  // One extra bit so the counter can never wrap before the compare fires.
  localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    REQUEST,
    WAIT,
    DRAIN
  } state_t;

  state_t          state_reg, state_next;
  logic            hold_valid_reg, hold_valid_next;
  logic [31:0]     hold_address_reg, hold_address_next;
  logic [31:0]     hold_data_reg, hold_data_next;
  logic            hold_error_reg, hold_error_next;
  logic [31:0]     req_address_reg, req_address_next;
  logic [CW-1:0]   counter_reg, counter_next;
  // Remembers an invalidate seen while the request was still waiting for ready.
  logic            kill_reg, kill_next;

  logic            hit;
  logic            timeout_expired;

  assign hit             = hold_valid_reg && (hold_address_reg == instructionAddress);
  // >= also covers the case where WAIT was left for DRAIN exactly at the limit.
  assign timeout_expired = (counter_reg >= TIMEOUT_LAST);

  assign instructionDataValid  = hit && !hold_error_reg;
  assign fetchFault            = hit && hold_error_reg;
  assign instructionData       = hold_data_reg;
  assign mem.memRequestValid   = (state_reg == REQUEST);
  assign mem.memRequestAddress = req_address_reg;

  // State register, asynchronously cleared so the bus request drops at once.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg        <= IDLE;
      hold_valid_reg   <= 1'b0;
      hold_address_reg <= 32'h0;
      hold_data_reg    <= 32'h0;
      hold_error_reg   <= 1'b0;
      req_address_reg  <= 32'h0;
      counter_reg      <= '0;
      kill_reg         <= 1'b0;
    end else begin
      state_reg        <= state_next;
      hold_valid_reg   <= hold_valid_next;
      hold_address_reg <= hold_address_next;
      hold_data_reg    <= hold_data_next;
      hold_error_reg   <= hold_error_next;
      req_address_reg  <= req_address_next;
      counter_reg      <= counter_next;
      kill_reg         <= kill_next;
    end
  end

  // Next-state logic: request sequencing, hold buffer updates and timeout.
  always_comb begin
    state_next        = state_reg;
    hold_valid_next   = hold_valid_reg;
    hold_address_next = hold_address_reg;
    hold_data_next    = hold_data_reg;
    hold_error_next   = hold_error_reg;
    req_address_next  = req_address_reg;
    counter_next      = '0;
    kill_next         = 1'b0;

    // Invalidate always drops the held word, whatever the bus is doing.
    if (invalidate) begin
      hold_valid_next = 1'b0;
    end

    case (state_reg)
      IDLE: begin
        if (!invalidate && !hit) begin
          if (instructionAddress[1:0] != 2'b00) begin
            // Misaligned PC faults locally; nothing goes to the bus.
            hold_valid_next   = 1'b1;
            hold_address_next = instructionAddress;
            hold_data_next    = 32'h0;
            hold_error_next   = 1'b1;
          end else begin
            req_address_next = instructionAddress;
            state_next       = REQUEST;
          end
        end
      end

      REQUEST: begin
        // Request stays up with a stable address until accepted.
        kill_next = kill_reg || invalidate;
        if (mem.memRequestReady) begin
          kill_next  = 1'b0;
          state_next = (kill_reg || invalidate) ? DRAIN : WAIT;
        end
      end

      WAIT: begin
        counter_next = counter_reg + CW'(1);
        if (mem.memResponseValid) begin
          if ((req_address_reg == instructionAddress) && !invalidate) begin
            hold_valid_next   = 1'b1;
            hold_address_next = req_address_reg;
            hold_data_next    = mem.memResponseData;
            hold_error_next   = mem.memResponseError;
          end
          counter_next = '0;
          state_next   = IDLE;
        end else if (invalidate) begin
          state_next = DRAIN;
        end else if (timeout_expired) begin
          hold_valid_next   = 1'b1;
          hold_address_next = req_address_reg;
          hold_data_next    = 32'h0;
          hold_error_next   = 1'b1;
          counter_next      = '0;
          state_next        = IDLE;
        end
      end

      DRAIN: begin
        // Swallow the response of a killed request; no fault on expiry.
        counter_next = counter_reg + CW'(1);
        if (mem.memResponseValid || timeout_expired) begin
          counter_next = '0;
          state_next   = IDLE;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule
